// File: rtl/store_issue_ctrl_pkg.sv
// Shared definitions for the store issue path: FSM states, exception causes and
// byte-lane alignment helpers that the load path can reuse.
package store_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISALIGN  = 2'd1,
        TRANSLATE = 2'd2,
        WAIT_SB   = 2'd3
    } st_state_e;

    localparam logic [3:0] CAUSE_ST_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ST_PAGE_FAULT = 4'd15;

    // Byte enables for an access of 2^size bytes starting at byte offset off.
    // Computed at 8-lane width; callers truncate to their own lane count.
    function automatic logic [7:0] be_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    // Moves LSB-justified data up to the byte lane given by off.
    function automatic logic [63:0] data_align(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/store_issue_ctrl.sv
// Store issue controller: accepts one store at a time, checks alignment,
// translates through the DTLB and pushes the physical store to the store buffer,
// returning a result (with optional exception) to writeback.
module store_issue_ctrl
    import store_issue_ctrl_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int VLEN       = 64,
    parameter int PLEN       = 56,
    parameter int TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [VLEN-1:0]       vaddr_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic [1:0]            size_i,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    output logic                  translation_req_o,
    output logic [VLEN-1:0]       vaddr_o,
    input  logic                  dtlb_hit_i,
    input  logic [PLEN-1:0]       paddr_i,
    input  logic                  pf_i,
    output logic                  sb_valid_o,
    output logic                  sb_valid_wo_flush_o,
    input  logic                  sb_ready_i,
    output logic [PLEN-1:0]       sb_paddr_o,
    output logic [XLEN-1:0]       sb_data_o,
    output logic [XLEN/8-1:0]     sb_be_o,
    output logic [1:0]            sb_size_o,
    output logic                  st_valid_o,
    output logic [TRANS_ID_W-1:0] st_trans_id_o,
    output logic                  st_ex_valid_o,
    output logic [3:0]            st_ex_cause_o,
    output logic [VLEN-1:0]       st_ex_tval_o
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int BEW  = XLEN / 8;

    st_state_e             state_q, state_d;
    logic [VLEN-1:0]       vaddr_q, vaddr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [BEW-1:0]        be_q, be_d;
    logic [1:0]            size_q, size_d;
    logic [TRANS_ID_W-1:0] tid_q, tid_d;
    logic [PLEN-1:0]       paddr_q, paddr_d;

    logic       done;
    logic       ex;
    logic [3:0] cause;
    logic       push_wo_flush;
    logic       ready;
    logic       accept;
    logic [2:0] off;
    logic       misaligned;
    logic [7:0] be_full;
    logic [63:0] data_full;

    // Alignment check and lane placement of the incoming op.
    always_comb begin
        off       = 3'(vaddr_i[OFFW-1:0]);
        be_full   = be_gen(size_i, off);
        data_full = data_align(64'(data_i), off);
        case (size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off[1:0] != 2'b00);
            default: misaligned = (XLEN == 32) || (off != 3'b000);
        endcase
    end

    // Next-state, completion and op-register update; flush overrides everything.
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        data_d        = data_q;
        be_d          = be_q;
        size_d        = size_q;
        tid_d         = tid_q;
        paddr_d       = paddr_q;
        done          = 1'b0;
        ex            = 1'b0;
        cause         = 4'd0;
        push_wo_flush = 1'b0;

        case (state_q)
            MISALIGN: begin
                done  = 1'b1;
                ex    = 1'b1;
                cause = CAUSE_ST_MISALIGNED;
            end
            TRANSLATE: begin
                if (dtlb_hit_i) begin
                    if (pf_i) begin
                        done  = 1'b1;
                        ex    = 1'b1;
                        cause = CAUSE_ST_PAGE_FAULT;
                    end else if (sb_ready_i) begin
                        done          = 1'b1;
                        push_wo_flush = 1'b1;
                    end else begin
                        paddr_d = paddr_i;
                        state_d = WAIT_SB;
                    end
                end
            end
            WAIT_SB: begin
                if (sb_ready_i) begin
                    done          = 1'b1;
                    push_wo_flush = 1'b1;
                end
            end
            default: ;
        endcase

        // A completing op frees the slot in the same cycle so issue can stream.
        ready  = rst_ni && !flush_i && ((state_q == IDLE) || done);
        accept = valid_i && ready;

        if (done) begin
            state_d = IDLE;
        end
        if (accept) begin
            vaddr_d = vaddr_i;
            data_d  = data_full[XLEN-1:0];
            be_d    = be_full[BEW-1:0];
            size_d  = size_i;
            tid_d   = trans_id_i;
            state_d = misaligned ? MISALIGN : TRANSLATE;
        end
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // State, op register and latched physical address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vaddr_q <= '0;
            data_q  <= '0;
            be_q    <= '0;
            size_q  <= '0;
            tid_q   <= '0;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            vaddr_q <= vaddr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            size_q  <= size_d;
            tid_q   <= tid_d;
            paddr_q <= paddr_d;
        end
    end

    assign ready_o             = ready;
    assign translation_req_o   = (state_q == TRANSLATE) && !flush_i;
    assign vaddr_o             = vaddr_q;
    assign sb_valid_wo_flush_o = push_wo_flush;
    assign sb_valid_o          = push_wo_flush && !flush_i;
    assign sb_paddr_o          = (state_q == TRANSLATE) ? paddr_i : paddr_q;
    assign sb_data_o           = data_q;
    assign sb_be_o             = be_q;
    assign sb_size_o           = size_q;
    assign st_valid_o          = done && !flush_i;
    assign st_trans_id_o       = tid_q;
    assign st_ex_valid_o       = st_valid_o && ex;
    assign st_ex_cause_o       = st_ex_valid_o ? cause : 4'd0;
    assign st_ex_tval_o        = st_ex_valid_o ? vaddr_q : '0;

endmodule

// File: tb/tb_store_issue_ctrl.sv
// Directed bench for store_issue_ctrl: inputs change on the falling edge,
// outputs are sampled 1ns later, state advances on the rising edge.
module tb_store_issue_ctrl;

    localparam int XLEN = 64;
    localparam int VLEN = 64;
    localparam int PLEN = 56;
    localparam int TIDW = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i, valid_i, ready_o;
    logic [VLEN-1:0] vaddr_i;
    logic [XLEN-1:0] data_i;
    logic [1:0]      size_i;
    logic [TIDW-1:0] trans_id_i;
    logic            translation_req_o;
    logic [VLEN-1:0] vaddr_o;
    logic            dtlb_hit_i;
    logic [PLEN-1:0] paddr_i;
    logic            pf_i;
    logic            sb_valid_o, sb_valid_wo_flush_o, sb_ready_i;
    logic [PLEN-1:0] sb_paddr_o;
    logic [XLEN-1:0] sb_data_o;
    logic [7:0]      sb_be_o;
    logic [1:0]      sb_size_o;
    logic            st_valid_o;
    logic [TIDW-1:0] st_trans_id_o;
    logic            st_ex_valid_o;
    logic [3:0]      st_ex_cause_o;
    logic [VLEN-1:0] st_ex_tval_o;

    int vecs = 0;
    int errs = 0;

    always #5 clk_i = ~clk_i;

    store_issue_ctrl #(.XLEN(XLEN), .VLEN(VLEN), .PLEN(PLEN), .TRANS_ID_W(TIDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .trans_id_i(trans_id_i),
        .translation_req_o(translation_req_o), .vaddr_o(vaddr_o), .dtlb_hit_i(dtlb_hit_i),
        .paddr_i(paddr_i), .pf_i(pf_i), .sb_valid_o(sb_valid_o),
        .sb_valid_wo_flush_o(sb_valid_wo_flush_o), .sb_ready_i(sb_ready_i),
        .sb_paddr_o(sb_paddr_o), .sb_data_o(sb_data_o), .sb_be_o(sb_be_o), .sb_size_o(sb_size_o),
        .st_valid_o(st_valid_o), .st_trans_id_o(st_trans_id_o), .st_ex_valid_o(st_ex_valid_o),
        .st_ex_cause_o(st_ex_cause_o), .st_ex_tval_o(st_ex_tval_o)
    );

    task automatic quiet_inputs();
        flush_i = 0; valid_i = 0; vaddr_i = '0; data_i = '0; size_i = 0; trans_id_i = 0;
        dtlb_hit_i = 0; paddr_i = '0; pf_i = 0; sb_ready_i = 0;
    endtask

    // Drives an op on the falling edge and lets the rising edge accept it.
    task automatic issue(input logic [VLEN-1:0] va, input logic [XLEN-1:0] d,
                         input logic [1:0] sz, input logic [TIDW-1:0] tid);
        @(negedge clk_i);
        quiet_inputs();
        valid_i = 1; vaddr_i = va; data_i = d; size_i = sz; trans_id_i = tid;
        @(posedge clk_i);
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_ni = 0;
        #1;
        vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL rst_ready got %b exp 0", ready_o); end
        vecs++; if (st_valid_o !== 1'b0) begin errs++; $display("FAIL rst_st_valid got %b exp 0", st_valid_o); end
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL rst_sb_valid got %b exp 0", sb_valid_o); end
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL rst_treq got %b exp 0", translation_req_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1;
        #1;
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL post_rst_ready got %b exp 1", ready_o); end
        vecs++; if (vaddr_o !== 64'h0) begin errs++; $display("FAIL post_rst_vaddr got %h exp 0", vaddr_o); end
        vecs++; if (sb_be_o !== 8'h00) begin errs++; $display("FAIL post_rst_be got %h exp 00", sb_be_o); end
    endtask

    task automatic test_sw_hit();
        issue(64'h1004, 64'hAABBCCDD, 2'd2, 3'd5);
        @(negedge clk_i);
        quiet_inputs();
        dtlb_hit_i = 1; sb_ready_i = 1; paddr_i = 56'h80001004;
        #1;
        vecs++; if (translation_req_o !== 1'b1) begin errs++; $display("FAIL sw_treq got %b exp 1", translation_req_o); end
        vecs++; if (vaddr_o !== 64'h1004) begin errs++; $display("FAIL sw_vaddr got %h exp 1004", vaddr_o); end
        vecs++; if (sb_valid_o !== 1'b1) begin errs++; $display("FAIL sw_sb_valid got %b exp 1", sb_valid_o); end
        vecs++; if (sb_be_o !== 8'hF0) begin errs++; $display("FAIL sw_be got %h exp f0", sb_be_o); end
        vecs++; if (sb_data_o !== 64'hAABBCCDD_00000000) begin errs++; $display("FAIL sw_data got %h exp aabbccdd00000000", sb_data_o); end
        vecs++; if (sb_paddr_o !== 56'h80001004) begin errs++; $display("FAIL sw_paddr got %h exp 80001004", sb_paddr_o); end
        vecs++; if (sb_size_o !== 2'd2) begin errs++; $display("FAIL sw_size got %0d exp 2", sb_size_o); end
        vecs++; if (st_valid_o !== 1'b1) begin errs++; $display("FAIL sw_st_valid got %b exp 1", st_valid_o); end
        vecs++; if (st_ex_valid_o !== 1'b0) begin errs++; $display("FAIL sw_ex got %b exp 0", st_ex_valid_o); end
        vecs++; if (st_trans_id_o !== 3'd5) begin errs++; $display("FAIL sw_tid got %0d exp 5", st_trans_id_o); end
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL sw_ready got %b exp 1", ready_o); end
        @(negedge clk_i);
        quiet_inputs();
        #1;
        vecs++; if (st_valid_o !== 1'b0) begin errs++; $display("FAIL sw_pulse got %b exp 0", st_valid_o); end
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL sw_idle_treq got %b exp 0", translation_req_o); end
    endtask

    task automatic test_misalign();
        issue(64'h1003, 64'h1234, 2'd1, 3'd2);
        @(negedge clk_i);
        quiet_inputs();
        dtlb_hit_i = 1; sb_ready_i = 1;
        #1;
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL mis_treq got %b exp 0", translation_req_o); end
        vecs++; if (st_valid_o !== 1'b1) begin errs++; $display("FAIL mis_st_valid got %b exp 1", st_valid_o); end
        vecs++; if (st_ex_valid_o !== 1'b1) begin errs++; $display("FAIL mis_ex got %b exp 1", st_ex_valid_o); end
        vecs++; if (st_ex_cause_o !== 4'd6) begin errs++; $display("FAIL mis_cause got %0d exp 6", st_ex_cause_o); end
        vecs++; if (st_ex_tval_o !== 64'h1003) begin errs++; $display("FAIL mis_tval got %h exp 1003", st_ex_tval_o); end
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL mis_sb_valid got %b exp 0", sb_valid_o); end
        vecs++; if (st_trans_id_o !== 3'd2) begin errs++; $display("FAIL mis_tid got %0d exp 2", st_trans_id_o); end
        @(negedge clk_i);
        quiet_inputs();
        #1;
        vecs++; if (st_valid_o !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b exp 0", st_valid_o); end
        // Word at offset 2 is misaligned too.
        issue(64'h1002, 64'h0, 2'd2, 3'd1);
        @(negedge clk_i);
        quiet_inputs();
        #1;
        vecs++; if (st_ex_cause_o !== 4'd6) begin errs++; $display("FAIL mis_w_cause got %0d exp 6", st_ex_cause_o); end
    endtask

    task automatic test_wait_sb();
        issue(64'h2008, 64'h11223344_55667788, 2'd3, 3'd3);
        @(negedge clk_i);
        quiet_inputs();
        dtlb_hit_i = 1; paddr_i = 56'hABC008;
        #1;
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL wsb_hit_sb_valid got %b exp 0", sb_valid_o); end
        vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL wsb_hit_ready got %b exp 0", ready_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            quiet_inputs();
            paddr_i = 56'h0DEAD0;
            #1;
            vecs++; if (sb_paddr_o !== 56'hABC008) begin errs++; $display("FAIL wsb_hold_paddr got %h exp abc008", sb_paddr_o); end
            vecs++; if (st_valid_o !== 1'b0 || sb_valid_o !== 1'b0) begin errs++; $display("FAIL wsb_hold_valid got %b%b exp 00", st_valid_o, sb_valid_o); end
            vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL wsb_hold_treq got %b exp 0", translation_req_o); end
        end
        @(negedge clk_i);
        quiet_inputs();
        sb_ready_i = 1;
        #1;
        vecs++; if (sb_valid_o !== 1'b1) begin errs++; $display("FAIL wsb_push got %b exp 1", sb_valid_o); end
        vecs++; if (st_valid_o !== 1'b1) begin errs++; $display("FAIL wsb_result got %b exp 1", st_valid_o); end
        vecs++; if (sb_be_o !== 8'hFF) begin errs++; $display("FAIL wsb_be got %h exp ff", sb_be_o); end
        vecs++; if (sb_data_o !== 64'h11223344_55667788) begin errs++; $display("FAIL wsb_data got %h exp 1122334455667788", sb_data_o); end
        vecs++; if (sb_paddr_o !== 56'hABC008) begin errs++; $display("FAIL wsb_paddr got %h exp abc008", sb_paddr_o); end
        vecs++; if (sb_valid_wo_flush_o !== 1'b1) begin errs++; $display("FAIL wsb_wof got %b exp 1", sb_valid_wo_flush_o); end
    endtask

    task automatic test_page_fault();
        issue(64'h3005, 64'h77, 2'd0, 3'd1);
        @(negedge clk_i);
        quiet_inputs();
        dtlb_hit_i = 1; pf_i = 1; sb_ready_i = 1; paddr_i = 56'h5005;
        #1;
        vecs++; if (st_valid_o !== 1'b1) begin errs++; $display("FAIL pf_st_valid got %b exp 1", st_valid_o); end
        vecs++; if (st_ex_cause_o !== 4'd15) begin errs++; $display("FAIL pf_cause got %0d exp 15", st_ex_cause_o); end
        vecs++; if (st_ex_tval_o !== 64'h3005) begin errs++; $display("FAIL pf_tval got %h exp 3005", st_ex_tval_o); end
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL pf_sb_valid got %b exp 0", sb_valid_o); end
        vecs++; if (sb_valid_wo_flush_o !== 1'b0) begin errs++; $display("FAIL pf_wof got %b exp 0", sb_valid_wo_flush_o); end
        @(negedge clk_i);
        quiet_inputs();
        sb_ready_i = 1;
        #1;
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL pf_after_sb_valid got %b exp 0", sb_valid_o); end
    endtask

    task automatic test_back_to_back();
        issue(64'h10, 64'hA5, 2'd0, 3'd4);
        @(negedge clk_i);
        quiet_inputs();
        valid_i = 1; vaddr_i = 64'h11; data_i = 64'h5A; size_i = 0; trans_id_i = 3'd6;
        dtlb_hit_i = 1; sb_ready_i = 1; paddr_i = 56'h9010;
        #1;
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL b2b_ready got %b exp 1", ready_o); end
        vecs++; if (sb_be_o !== 8'h01) begin errs++; $display("FAIL b2b_be0 got %h exp 01", sb_be_o); end
        vecs++; if (sb_data_o !== 64'hA5) begin errs++; $display("FAIL b2b_data0 got %h exp a5", sb_data_o); end
        vecs++; if (st_trans_id_o !== 3'd4) begin errs++; $display("FAIL b2b_tid0 got %0d exp 4", st_trans_id_o); end
        @(negedge clk_i);
        valid_i = 0; paddr_i = 56'h9011;
        #1;
        vecs++; if (translation_req_o !== 1'b1) begin errs++; $display("FAIL b2b_treq1 got %b exp 1", translation_req_o); end
        vecs++; if (sb_be_o !== 8'h02) begin errs++; $display("FAIL b2b_be1 got %h exp 02", sb_be_o); end
        vecs++; if (sb_data_o !== 64'h5A00) begin errs++; $display("FAIL b2b_data1 got %h exp 5a00", sb_data_o); end
        vecs++; if (st_valid_o !== 1'b1 || st_trans_id_o !== 3'd6) begin errs++; $display("FAIL b2b_res1 got %b/%0d exp 1/6", st_valid_o, st_trans_id_o); end
        @(negedge clk_i);
        quiet_inputs();
        #1;
        vecs++; if (st_valid_o !== 1'b0) begin errs++; $display("FAIL b2b_end got %b exp 0", st_valid_o); end
    endtask

    task automatic test_flush();
        issue(64'h4000, 64'hCAFE, 2'd2, 3'd7);
        @(negedge clk_i);
        quiet_inputs();
        flush_i = 1; dtlb_hit_i = 1; sb_ready_i = 1; paddr_i = 56'h4000;
        #1;
        vecs++; if (sb_valid_o !== 1'b0) begin errs++; $display("FAIL fl_sb_valid got %b exp 0", sb_valid_o); end
        vecs++; if (st_valid_o !== 1'b0) begin errs++; $display("FAIL fl_st_valid got %b exp 0", st_valid_o); end
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL fl_treq got %b exp 0", translation_req_o); end
        vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL fl_ready got %b exp 0", ready_o); end
        vecs++; if (sb_valid_wo_flush_o !== 1'b1) begin errs++; $display("FAIL fl_wof got %b exp 1", sb_valid_wo_flush_o); end
        @(negedge clk_i);
        flush_i = 0;
        #1;
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL fl_idle_treq got %b exp 0", translation_req_o); end
        vecs++; if (st_valid_o !== 1'b0 || sb_valid_o !== 1'b0) begin errs++; $display("FAIL fl_idle_valid got %b%b exp 00", st_valid_o, sb_valid_o); end
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL fl_idle_ready got %b exp 1", ready_o); end
    endtask

    task automatic test_reset_midop();
        issue(64'h5000, 64'h1, 2'd2, 3'd3);
        @(negedge clk_i);
        quiet_inputs();
        rst_ni = 0;
        #1;
        vecs++; if (translation_req_o !== 1'b0) begin errs++; $display("FAIL rmid_treq got %b exp 0", translation_req_o); end
        @(negedge clk_i);
        rst_ni = 1; dtlb_hit_i = 1; sb_ready_i = 1;
        #1;
        vecs++; if (st_valid_o !== 1'b0 || sb_valid_o !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b%b exp 00", st_valid_o, sb_valid_o); end
        vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL rmid_ready got %b exp 1", ready_o); end
    endtask

    initial begin
        test_reset();
        test_sw_hit();
        test_misalign();
        test_wait_sb();
        test_page_fault();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
